// File: rtl/calc_entry_ctrl.sv
// Calculator key-entry controller: collects BCD operands and an operator from the keypad,
// then drives the BCD ALU through a start/done handshake.
module calc_entry_ctrl #(
  parameter  int NDIGITS = 4,
  parameter  int OPW     = 2,
  localparam int W       = 4 * NDIGITS
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           key_valid,
  input  logic [1:0]     key_type,
  input  logic [3:0]     key_num,
  input  logic [OPW-1:0] key_op,
  output logic           key_ready,
  output logic           alu_start,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic           alu_done,
  input  logic [W-1:0]   alu_result,
  input  logic           alu_err,
  output logic [W-1:0]   disp_bcd,
  output logic [2:0]     state,
  output logic           err
);

  localparam int CW = $clog2(NDIGITS + 1);

  localparam logic [2:0] S_N1   = 3'd0;
  localparam logic [2:0] S_OP   = 3'd1;
  localparam logic [2:0] S_N2   = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_RES  = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam logic [1:0] K_DIGIT = 2'b00;
  localparam logic [1:0] K_OP    = 2'b01;
  localparam logic [1:0] K_EQ    = 2'b10;
  localparam logic [1:0] K_CLR   = 2'b11;

  logic [2:0]     state_q, state_d;
  logic [W-1:0]   num1_q, num1_d, num2_q, num2_d, disp_q, disp_d;
  logic [OPW-1:0] op_q, op_d, op_next_q, op_next_d;
  logic [CW-1:0]  cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic           chain_q, chain_d;
  logic           start_q, start_d, ready_q, ready_d, err_q, err_d;
  logic           key_fire_s, digit_ok_s, clear_s;

  assign key_fire_s = key_valid && ready_q;
  assign digit_ok_s = (key_num <= 4'd9);

  // Next-state and datapath update; a key only has effect on the edge that accepts it.
  always_comb begin
    state_d   = state_q;
    num1_d    = num1_q;
    num2_d    = num2_q;
    op_d      = op_q;
    op_next_d = op_next_q;
    cnt1_d    = cnt1_q;
    cnt2_d    = cnt2_q;
    chain_d   = chain_q;
    clear_s   = 1'b0;

    case (state_q)
      S_N1: begin
        if (key_fire_s) begin
          case (key_type)
            K_DIGIT: begin
              if (digit_ok_s && (cnt1_q < CW'(NDIGITS))) begin
                num1_d = {num1_q[W-5:0], key_num};
                cnt1_d = cnt1_q + CW'(1);
              end else begin
                num1_d = num1_q;
              end
            end
            K_OP: begin
              op_d    = key_op;
              state_d = S_OP;
            end
            K_CLR:   clear_s = 1'b1;
            default: state_d = state_q;
          endcase
        end else begin
          state_d = state_q;
        end
      end
      S_OP: begin
        if (key_fire_s) begin
          case (key_type)
            K_OP: op_d = key_op;
            K_DIGIT: begin
              if (digit_ok_s) begin
                num2_d  = {{(W-4){1'b0}}, key_num};
                cnt2_d  = CW'(1);
                state_d = S_N2;
              end else begin
                state_d = state_q;
              end
            end
            K_CLR:   clear_s = 1'b1;
            default: state_d = state_q;
          endcase
        end else begin
          state_d = state_q;
        end
      end
      S_N2: begin
        if (key_fire_s) begin
          case (key_type)
            K_DIGIT: begin
              if (digit_ok_s && (cnt2_q < CW'(NDIGITS))) begin
                num2_d = {num2_q[W-5:0], key_num};
                cnt2_d = cnt2_q + CW'(1);
              end else begin
                num2_d = num2_q;
              end
            end
            K_EQ: begin
              chain_d = 1'b0;
              state_d = S_WAIT;
            end
            K_OP: begin
              op_next_d = key_op;
              chain_d   = 1'b1;
              state_d   = S_WAIT;
            end
            K_CLR:   clear_s = 1'b1;
            default: state_d = state_q;
          endcase
        end else begin
          state_d = state_q;
        end
      end
      S_WAIT: begin
        if (alu_done) begin
          if (alu_err) begin
            state_d = S_ERR;
          end else begin
            num1_d = alu_result;
            cnt1_d = CW'(NDIGITS);
            if (chain_q) begin
              op_d    = op_next_q;
              state_d = S_OP;
            end else begin
              state_d = S_RES;
            end
          end
        end else begin
          state_d = state_q;
        end
      end
      S_RES: begin
        if (key_fire_s) begin
          case (key_type)
            K_DIGIT: begin
              if (digit_ok_s) begin
                num1_d  = {{(W-4){1'b0}}, key_num};
                cnt1_d  = CW'(1);
                num2_d  = {W{1'b0}};
                state_d = S_N1;
              end else begin
                state_d = state_q;
              end
            end
            K_OP: begin
              op_d    = key_op;
              state_d = S_OP;
            end
            K_EQ: begin
              chain_d = 1'b0;
              state_d = S_WAIT;
            end
            K_CLR:   clear_s = 1'b1;
            default: state_d = state_q;
          endcase
        end else begin
          state_d = state_q;
        end
      end
      S_ERR: begin
        if (key_fire_s && (key_type == K_CLR)) begin
          clear_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = S_N1;
    endcase

    if (clear_s) begin
      num1_d    = {W{1'b0}};
      num2_d    = {W{1'b0}};
      op_d      = {OPW{1'b0}};
      op_next_d = {OPW{1'b0}};
      cnt1_d    = {CW{1'b0}};
      cnt2_d    = {CW{1'b0}};
      chain_d   = 1'b0;
      state_d   = S_N1;
    end else begin
      chain_d = chain_d;
    end

    // Output registers are loaded from the next state so they line up with state_q.
    ready_d = (state_d != S_WAIT);
    err_d   = (state_d == S_ERR);
    start_d = (state_d == S_WAIT) && (state_q != S_WAIT);
    case (state_d)
      S_N2, S_WAIT: disp_d = num2_d;
      S_ERR:        disp_d = {W{1'b1}};
      default:      disp_d = num1_d;
    endcase
  end

  // State, operand and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_N1;
      num1_q    <= {W{1'b0}};
      num2_q    <= {W{1'b0}};
      op_q      <= {OPW{1'b0}};
      op_next_q <= {OPW{1'b0}};
      cnt1_q    <= {CW{1'b0}};
      cnt2_q    <= {CW{1'b0}};
      chain_q   <= 1'b0;
      start_q   <= 1'b0;
      ready_q   <= 1'b1;
      err_q     <= 1'b0;
      disp_q    <= {W{1'b0}};
    end else begin
      state_q   <= state_d;
      num1_q    <= num1_d;
      num2_q    <= num2_d;
      op_q      <= op_d;
      op_next_q <= op_next_d;
      cnt1_q    <= cnt1_d;
      cnt2_q    <= cnt2_d;
      chain_q   <= chain_d;
      start_q   <= start_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      disp_q    <= disp_d;
    end
  end

  assign key_ready = ready_q;
  assign alu_start = start_q;
  assign alu_a     = num1_q;
  assign alu_b     = num2_q;
  assign alu_op    = op_q;
  assign disp_bcd  = disp_q;
  assign state     = state_q;
  assign err       = err_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed bench for calc_entry_ctrl: a key-entry vector table plus hand-written ALU handshake sequences.
module tb_calc_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [1:0]  key_type = 2'b00;
  logic [3:0]  key_num = 4'd0;
  logic [1:0]  key_op = 2'b00;
  logic        key_ready, alu_start, alu_done = 1'b0, alu_err = 1'b0, err;
  logic [15:0] alu_a, alu_b, alu_result = 16'h0000, disp_bcd;
  logic [1:0]  alu_op;
  logic [2:0]  state;

  int tests = 0;
  int fails = 0;

  localparam logic [2:0] N1 = 3'd0, OP = 3'd1, N2 = 3'd2, WT = 3'd3, RES = 3'd4, ER = 3'd5;
  localparam logic [1:0] KD = 2'b00, KO = 2'b01, KE = 2'b10, KC = 2'b11;

  typedef struct {
    logic [1:0]  kt;
    logic [3:0]  kn;
    logic [1:0]  ko;
    logic [2:0]  st;
    logic [15:0] disp;
  } vec_t;

  vec_t vecs[15];

  calc_entry_ctrl #(.NDIGITS(4), .OPW(2)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_type(key_type), .key_num(key_num),
    .key_op(key_op), .key_ready(key_ready), .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err),
    .disp_bcd(disp_bcd), .state(state), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic press(input logic [1:0] t, input logic [3:0] n, input logic [1:0] o);
    @(negedge clk);
    key_valid = 1'b1; key_type = t; key_num = n; key_op = o;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic alu_finish(input logic [15:0] res, input logic e);
    @(negedge clk);
    alu_done = 1'b1; alu_result = res; alu_err = e;
    @(posedge clk); #1;
    alu_done = 1'b0; alu_err = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{KD, 4'd1, 2'd0, N1, 16'h0001};
    vecs[1]  = '{KD, 4'd2, 2'd0, N1, 16'h0012};
    vecs[2]  = '{KD, 4'd3, 2'd0, N1, 16'h0123};
    vecs[3]  = '{KD, 4'd4, 2'd0, N1, 16'h1234};
    vecs[4]  = '{KD, 4'd5, 2'd0, N1, 16'h1234};
    vecs[5]  = '{KE, 4'd0, 2'd0, N1, 16'h1234};
    vecs[6]  = '{KC, 4'd0, 2'd0, N1, 16'h0000};
    vecs[7]  = '{KD, 4'hA, 2'd0, N1, 16'h0000};
    vecs[8]  = '{KD, 4'd1, 2'd0, N1, 16'h0001};
    vecs[9]  = '{KD, 4'd2, 2'd0, N1, 16'h0012};
    vecs[10] = '{KO, 4'd0, 2'd2, OP, 16'h0012};
    vecs[11] = '{KO, 4'd0, 2'd0, OP, 16'h0012};
    vecs[12] = '{KD, 4'hA, 2'd0, OP, 16'h0012};
    vecs[13] = '{KE, 4'd0, 2'd0, OP, 16'h0012};
    vecs[14] = '{KD, 4'd3, 2'd0, N2, 16'h0003};

    #12;
    chk("rst_state", 16'(state), 16'(N1));
    chk("rst_ready", 16'(key_ready), 16'd1);
    chk("rst_start", 16'(alu_start), 16'd0);
    chk("rst_disp", disp_bcd, 16'h0000);
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      press(vecs[i].kt, vecs[i].kn, vecs[i].ko);
      chk($sformatf("vec%0d_state", i), 16'(state), 16'(vecs[i].st));
      chk($sformatf("vec%0d_disp", i), disp_bcd, vecs[i].disp);
    end

    // 12 op 3 = : one start pulse, operands stable
    press(KE, 4'd0, 2'd0);
    chk("eq_state", 16'(state), 16'(WT));
    chk("eq_start", 16'(alu_start), 16'd1);
    chk("eq_ready", 16'(key_ready), 16'd0);
    chk("eq_a", alu_a, 16'h0012);
    chk("eq_b", alu_b, 16'h0003);
    chk("eq_op", 16'(alu_op), 16'd0);
    @(posedge clk); #1;
    chk("eq_start_once", 16'(alu_start), 16'd0);
    chk("eq_still_wait", 16'(state), 16'(WT));
    alu_finish(16'h0015, 1'b0);
    chk("res_state", 16'(state), 16'(RES));
    chk("res_disp", disp_bcd, 16'h0015);

    // Repeat-equals, with a dropped key during WAIT
    press(KE, 4'd0, 2'd0);
    chk("rep_state", 16'(state), 16'(WT));
    chk("rep_start", 16'(alu_start), 16'd1);
    chk("rep_a", alu_a, 16'h0015);
    chk("rep_b", alu_b, 16'h0003);
    press(KD, 4'd7, 2'd0);
    chk("wait_key_b", alu_b, 16'h0003);
    chk("wait_key_state", 16'(state), 16'(WT));
    alu_finish(16'h0018, 1'b0);
    chk("rep_res_state", 16'(state), 16'(RES));
    chk("rep_res_disp", disp_bcd, 16'h0018);

    // Chain: 5 op00 3 op01
    press(KC, 4'd0, 2'd0);
    chk("clr_res_state", 16'(state), 16'(N1));
    press(KD, 4'd5, 2'd0);
    press(KO, 4'd0, 2'd0);
    press(KD, 4'd3, 2'd0);
    press(KO, 4'd0, 2'd1);
    chk("chain_wait", 16'(state), 16'(WT));
    chk("chain_a", alu_a, 16'h0005);
    chk("chain_op0", 16'(alu_op), 16'd0);
    alu_finish(16'h0008, 1'b0);
    chk("chain_state", 16'(state), 16'(OP));
    chk("chain_op1", 16'(alu_op), 16'd1);
    chk("chain_num1", alu_a, 16'h0008);
    chk("chain_disp", disp_bcd, 16'h0008);
    press(KD, 4'd2, 2'd0);
    press(KE, 4'd0, 2'd0);
    chk("chain2_a", alu_a, 16'h0008);
    chk("chain2_b", alu_b, 16'h0002);
    chk("chain2_op", 16'(alu_op), 16'd1);

    // ALU error path
    alu_finish(16'h0000, 1'b1);
    chk("err_state", 16'(state), 16'(ER));
    chk("err_flag", 16'(err), 16'd1);
    chk("err_disp", disp_bcd, 16'hFFFF);
    press(KD, 4'd3, 2'd0);
    chk("err_drop", 16'(state), 16'(ER));
    press(KC, 4'd0, 2'd0);
    chk("errclr_state", 16'(state), 16'(N1));
    chk("errclr_err", 16'(err), 16'd0);
    chk("errclr_a", alu_a, 16'h0000);
    chk("errclr_b", alu_b, 16'h0000);
    chk("errclr_op", 16'(alu_op), 16'd0);
    chk("errclr_disp", disp_bcd, 16'h0000);

    // Asynchronous reset mid-WAIT, then a late alu_done
    press(KD, 4'd1, 2'd0);
    press(KO, 4'd0, 2'd3);
    press(KD, 4'd2, 2'd0);
    press(KE, 4'd0, 2'd0);
    chk("r6_wait", 16'(state), 16'(WT));
    @(negedge clk);
    alu_done = 1'b1; alu_result = 16'h0099;
    #2 rst = 1'b0;
    #1;
    chk("r6_async_state", 16'(state), 16'(N1));
    chk("r6_async_ready", 16'(key_ready), 16'd1);
    chk("r6_async_a", alu_a, 16'h0000);
    chk("r6_async_b", alu_b, 16'h0000);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    alu_done = 1'b0;
    chk("r6_late_state", 16'(state), 16'(N1));
    chk("r6_late_num1", alu_a, 16'h0000);
    chk("r6_late_start", 16'(alu_start), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
